// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared constants, state encoding and priority helper for the APB decoder
package apb_pkg;

  localparam int NUM_SLAVES = 3;
  localparam int IDX_W      = 2;
  localparam int WAIT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  // Lowest set bit wins so overlapping regions resolve to the lowest slave index.
  function automatic logic [IDX_W-1:0] first_hit(input logic [NUM_SLAVES-1:0] hit);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/apb_addr_match.sv
// rtl/apb_addr_match.sv - base/mask region compare producing a hit vector and priority index
module apb_addr_match
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]                 paddr,
  input  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] bases,
  input  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] masks,
  output logic [NUM_SLAVES-1:0]                 hit,
  output logic [IDX_W-1:0]                      hit_idx
);

  // Compare the masked address against every region base in parallel.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit[i] = ((paddr & masks[i]) == bases[i]);
    end
    hit_idx = first_hit(hit);
  end

endmodule

// File: rtl/apb_decoder.sv
// rtl/apb_decoder.sv - one-to-three APB decoder with unmapped-error response and wait-state timeout
module apb_decoder
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] S0_BASE        = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] S0_MASK        = 32'hF000_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_BASE        = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_MASK        = 32'hF000_0000,
  parameter logic [ADDR_WIDTH-1:0] S2_BASE        = 32'h2000_0000,
  parameter logic [ADDR_WIDTH-1:0] S2_MASK        = 32'hF000_0000,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // upstream (from the single initiator)
  input  logic                      master_psel,
  input  logic                      master_penable,
  input  logic [ADDR_WIDTH-1:0]     master_paddr,
  input  logic [2:0]                master_pprot,
  input  logic                      master_pwrite,
  input  logic [DATA_WIDTH-1:0]     master_pwdata,
  input  logic [DATA_WIDTH/8-1:0]   master_pstrb,
  output logic                      master_pready,
  output logic [DATA_WIDTH-1:0]     master_prdata,
  output logic                      master_pslverr,
  // slave 0
  output logic                      slave0_psel,
  output logic                      slave0_penable,
  output logic [ADDR_WIDTH-1:0]     slave0_paddr,
  output logic [2:0]                slave0_pprot,
  output logic                      slave0_pwrite,
  output logic [DATA_WIDTH-1:0]     slave0_pwdata,
  output logic [DATA_WIDTH/8-1:0]   slave0_pstrb,
  input  logic                      slave0_pready,
  input  logic [DATA_WIDTH-1:0]     slave0_prdata,
  input  logic                      slave0_pslverr,
  // slave 1
  output logic                      slave1_psel,
  output logic                      slave1_penable,
  output logic [ADDR_WIDTH-1:0]     slave1_paddr,
  output logic [2:0]                slave1_pprot,
  output logic                      slave1_pwrite,
  output logic [DATA_WIDTH-1:0]     slave1_pwdata,
  output logic [DATA_WIDTH/8-1:0]   slave1_pstrb,
  input  logic                      slave1_pready,
  input  logic [DATA_WIDTH-1:0]     slave1_prdata,
  input  logic                      slave1_pslverr,
  // slave 2
  output logic                      slave2_psel,
  output logic                      slave2_penable,
  output logic [ADDR_WIDTH-1:0]     slave2_paddr,
  output logic [2:0]                slave2_pprot,
  output logic                      slave2_pwrite,
  output logic [DATA_WIDTH-1:0]     slave2_pwdata,
  output logic [DATA_WIDTH/8-1:0]   slave2_pstrb,
  input  logic                      slave2_pready,
  input  logic [DATA_WIDTH-1:0]     slave2_prdata,
  input  logic                      slave2_pslverr,
  // abort indication
  output logic                      timeout_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [WAIT_W-1:0] TIMEOUT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

  localparam logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] BASES = {S2_BASE, S1_BASE, S0_BASE};
  localparam logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] MASKS = {S2_MASK, S1_MASK, S0_MASK};

  state_t                                  state_q, state_d;
  logic [IDX_W-1:0]                        idx_q;
  logic [WAIT_W-1:0]                       cnt_q;

  logic [NUM_SLAVES-1:0]                   hit;
  logic                                    hit_any;
  logic [IDX_W-1:0]                        hit_idx;

  logic                                    fwd_valid;
  logic                                    fwd_en;
  logic [IDX_W-1:0]                        fwd_idx;
  logic                                    sel_pready;

  logic [NUM_SLAVES-1:0]                   s_psel, s_penable, s_pwrite;
  logic [NUM_SLAVES-1:0]                   s_pready, s_pslverr;
  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]   s_paddr;
  logic [NUM_SLAVES-1:0][2:0]              s_pprot;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]   s_pwdata, s_prdata;
  logic [NUM_SLAVES-1:0][STRB_WIDTH-1:0]   s_pstrb;

  apb_addr_match #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_match (
    .paddr   (master_paddr),
    .bases   (BASES),
    .masks   (MASKS),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  assign hit_any    = |hit;
  assign s_pready   = {slave2_pready,  slave1_pready,  slave0_pready};
  assign s_pslverr  = {slave2_pslverr, slave1_pslverr, slave0_pslverr};
  assign s_prdata   = {slave2_prdata,  slave1_prdata,  slave0_prdata};
  assign sel_pready = s_pready[idx_q];

  // Next-state, target selection and upstream response; everything is forced quiet while in reset.
  always_comb begin
    state_d        = state_q;
    fwd_valid      = 1'b0;
    fwd_en         = 1'b0;
    fwd_idx        = '0;
    master_pready  = 1'b0;
    master_prdata  = '0;
    master_pslverr = 1'b0;
    timeout_o      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (master_psel && !master_penable) begin
          fwd_valid = hit_any;
          fwd_idx   = hit_idx;
          state_d   = hit_any ? ST_ACCESS : ST_ERR;
        end
      end
      ST_ACCESS: begin
        if (!master_psel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TIMEOUT_LIMIT) begin
          master_pready  = 1'b1;
          master_pslverr = 1'b1;
          timeout_o      = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          fwd_valid = 1'b1;
          fwd_idx   = idx_q;
          fwd_en    = master_penable;
          if (master_penable) begin
            master_pready  = sel_pready;
            master_prdata  = s_prdata[idx_q];
            master_pslverr = s_pslverr[idx_q];
            if (sel_pready) state_d = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        if (!master_psel) begin
          state_d = ST_IDLE;
        end else if (master_penable) begin
          master_pready  = 1'b1;
          master_pslverr = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rst_n) begin
      fwd_valid      = 1'b0;
      fwd_en         = 1'b0;
      master_pready  = 1'b0;
      master_prdata  = '0;
      master_pslverr = 1'b0;
      timeout_o      = 1'b0;
    end
  end

  // Fan the request out to the selected slave only; the others see all-zero signals.
  always_comb begin
    s_psel    = '0;
    s_penable = '0;
    s_pwrite  = '0;
    s_paddr   = '0;
    s_pprot   = '0;
    s_pwdata  = '0;
    s_pstrb   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (fwd_valid && (fwd_idx == IDX_W'(i))) begin
        s_psel[i]    = 1'b1;
        s_penable[i] = fwd_en;
        s_pwrite[i]  = master_pwrite;
        s_paddr[i]   = master_paddr;
        s_pprot[i]   = master_pprot;
        s_pwdata[i]  = master_pwdata;
        s_pstrb[i]   = master_pstrb;
      end
    end
  end

  // State, latched target and wait counter; the counter restarts whenever the FSM heads back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && master_psel && !master_penable) begin
        idx_q <= hit_idx;
      end
      if (state_d == ST_IDLE) begin
        cnt_q <= '0;
      end else if (state_q == ST_ACCESS && master_penable && !sel_pready) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign slave0_psel    = s_psel[0];
  assign slave0_penable = s_penable[0];
  assign slave0_paddr   = s_paddr[0];
  assign slave0_pprot   = s_pprot[0];
  assign slave0_pwrite  = s_pwrite[0];
  assign slave0_pwdata  = s_pwdata[0];
  assign slave0_pstrb   = s_pstrb[0];

  assign slave1_psel    = s_psel[1];
  assign slave1_penable = s_penable[1];
  assign slave1_paddr   = s_paddr[1];
  assign slave1_pprot   = s_pprot[1];
  assign slave1_pwrite  = s_pwrite[1];
  assign slave1_pwdata  = s_pwdata[1];
  assign slave1_pstrb   = s_pstrb[1];

  assign slave2_psel    = s_psel[2];
  assign slave2_penable = s_penable[2];
  assign slave2_paddr   = s_paddr[2];
  assign slave2_pprot   = s_pprot[2];
  assign slave2_pwrite  = s_pwrite[2];
  assign slave2_pwdata  = s_pwdata[2];
  assign slave2_pstrb   = s_pstrb[2];

endmodule
